// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: owns the ALU control inputs. It issues one operation per
// start request. Single-cycle ops (ADD/SUB/AND/OR/XOR/SWAP) finish after one
// execute cycle. 8x8 multiplies run as 8 shift-add passes through the ALU adder.
// The result and flags are registered, and a one-cycle done pulse marks completion.
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        imm_en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [7:0]  imm,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [7:0]  alu_instr,
  output logic        alu_y_src_sel,
  output logic [2:0]  alu_z_src_sel,
  output logic        alu_add_sub_sel,
  input  logic [15:0] alu_z,
  input  logic        alu_cy,
  input  logic        alu_ov,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_cy,
  output logic        flag_ov,
  output logic        flag_z,
  output logic        flag_s
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000, OP_SUB  = 3'b001, OP_AND  = 3'b010, OP_OR   = 3'b011,
    OP_XOR  = 3'b100, OP_SWAP = 3'b101, OP_UMUL = 3'b110, OP_SMUL = 3'b111
  } op_t;

  state_t      state;
  op_t         op_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [7:0]  imm_r;
  logic        imm_en_r;
  logic [2:0]  cnt;
  logic [15:0] acc;

  logic        is_arith;
  logic [15:0] mcand;

  assign is_arith = (op_r == OP_ADD) || (op_r == OP_SUB);
  assign mcand    = (op_r == OP_SMUL) ? {{8{a_r[7]}}, a_r[7:0]} : {8'h00, a_r[7:0]};

  // ALU control decode from registered state; everything is zero outside EXEC/MUL.
  always_comb begin
    alu_x           = '0;
    alu_y           = '0;
    alu_instr       = '0;
    alu_y_src_sel   = 1'b0;
    alu_z_src_sel   = 3'b000;
    alu_add_sub_sel = 1'b0;
    case (state)
      S_EXEC: begin
        alu_x           = a_r;
        alu_y           = b_r;
        alu_instr       = imm_r;
        alu_add_sub_sel = (op_r == OP_SUB);
        alu_y_src_sel   = imm_en_r & is_arith;
        case (op_r)
          OP_AND:  alu_z_src_sel = 3'b001;
          OP_OR:   alu_z_src_sel = 3'b010;
          OP_XOR:  alu_z_src_sel = 3'b011;
          OP_SWAP: alu_z_src_sel = 3'b101;
          default: alu_z_src_sel = 3'b000;
        endcase
      end
      S_MUL: begin
        alu_x = acc;
        alu_y = b_r[cnt] ? (mcand << cnt) : '0;
        // The multiplier MSB carries weight -2^7 for signed multiplies.
        alu_add_sub_sel = (op_r == OP_SMUL) && (cnt == 3'd7);
      end
      default: ;
    endcase
  end

  // Sequencer FSM: accept, execute or iterate, then register result, flags and done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      imm_r    <= '0;
      imm_en_r <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      flag_cy  <= 1'b0;
      flag_ov  <= 1'b0;
      flag_z   <= 1'b0;
      flag_s   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r     <= op_t'(op);
            a_r      <= a;
            b_r      <= b;
            imm_r    <= imm;
            imm_en_r <= imm_en;
            cnt      <= '0;
            acc      <= '0;
            busy     <= 1'b1;
            state    <= op[2] & op[1] ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          result <= alu_z;
          flag_z <= (alu_z == 16'h0000);
          flag_s <= alu_z[15];
          if (is_arith) begin
            flag_cy <= alu_cy;
            flag_ov <= alu_ov;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_MUL: begin
          acc <= alu_z;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result <= alu_z;
            flag_z <= (alu_z == 16'h0000);
            flag_s <= alu_z[15];
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. A combinational ALU model answers the
// sequencer's drive outputs. Expected results come from an arithmetic
// reference model of each operation.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic        imm_en = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [7:0]  imm = '0;
  logic [15:0] alu_x, alu_y, alu_z, result;
  logic [7:0]  alu_instr;
  logic        alu_y_src_sel, alu_add_sub_sel, alu_cy, alu_ov;
  logic [2:0]  alu_z_src_sel;
  logic        busy, done, flag_cy, flag_ov, flag_z, flag_s;

  int errors = 0;
  int checks = 0;
  logic m_cy = 1'b0, m_ov = 1'b0;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .imm_en(imm_en),
    .a(a), .b(b), .imm(imm),
    .alu_x(alu_x), .alu_y(alu_y), .alu_instr(alu_instr),
    .alu_y_src_sel(alu_y_src_sel), .alu_z_src_sel(alu_z_src_sel),
    .alu_add_sub_sel(alu_add_sub_sel),
    .alu_z(alu_z), .alu_cy(alu_cy), .alu_ov(alu_ov),
    .busy(busy), .done(done), .result(result),
    .flag_cy(flag_cy), .flag_ov(flag_ov), .flag_z(flag_z), .flag_s(flag_s)
  );

  always #5 clk = ~clk;

  // ALU model: the Y mux picks the immediate byte when selected.
  // Subtract is computed as x + ~y + 1, so carry means "no borrow".
  logic [15:0] yv, eff;
  logic [16:0] s17;
  always_comb begin
    yv  = alu_y_src_sel ? {8'h00, alu_instr} : alu_y;
    eff = alu_add_sub_sel ? ~yv : yv;
    s17 = {1'b0, alu_x} + {1'b0, eff} + {16'h0000, alu_add_sub_sel};
    alu_cy = s17[16];
    alu_ov = (alu_x[15] == eff[15]) && (s17[15] != alu_x[15]);
    case (alu_z_src_sel)
      3'b000:  alu_z = s17[15:0];
      3'b001:  alu_z = alu_x & yv;
      3'b010:  alu_z = alu_x | yv;
      3'b011:  alu_z = alu_x ^ yv;
      3'b101:  alu_z = {alu_x[7:0], alu_x[15:8]};
      default: alu_z = '0;
    endcase
  end

  // Reference model: returns {cy, ov, result}. Non-arithmetic ops keep the prior cy/ov.
  function automatic logic [17:0] ref_op(input logic [2:0] o, input logic [15:0] xa, xb,
                                         input logic [7:0] xi, input logic xe,
                                         input logic pcy, pov);
    logic [15:0] y, r;
    logic [16:0] s;
    logic cy, ov;
    int sa, sb, p;
    cy = pcy; ov = pov; r = '0;
    y = xe ? {8'h00, xi} : xb;
    case (o)
      3'd0: begin s = {1'b0, xa} + {1'b0, y}; r = s[15:0]; cy = s[16];
                  ov = (xa[15] == y[15]) && (r[15] != xa[15]); end
      3'd1: begin r = xa - y; cy = (xa >= y);
                  ov = (xa[15] != y[15]) && (r[15] != xa[15]); end
      3'd2: r = xa & xb;
      3'd3: r = xa | xb;
      3'd4: r = xa ^ xb;
      3'd5: r = {xa[7:0], xa[15:8]};
      3'd6: begin p = int'(xa[7:0]) * int'(xb[7:0]); r = p[15:0]; end
      default: begin
        sa = xa[7] ? int'(xa[7:0]) - 256 : int'(xa[7:0]);
        sb = xb[7] ? int'(xb[7:0]) - 256 : int'(xb[7:0]);
        p = sa * sb; r = p[15:0];
      end
    endcase
    return {cy, ov, r};
  endfunction

  // Issue one request and wait (bounded) for done. This task only observes; the callers compare.
  // sel = {y_src, z_src, add_sub} sampled in the first cycle after acceptance.
  task automatic issue(input logic [2:0] o, input logic [15:0] xa, xb, input logic [7:0] xi,
                       input logic xe, output int lat, output logic [4:0] sel, output logic bsy);
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb; imm = xi; imm_en = xe;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); imm = 8'($urandom); imm_en = 1'($urandom);
    bsy = busy;
    sel = {alu_y_src_sel, alu_z_src_sel, alu_add_sub_sel};
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({busy, done, result, flag_cy, flag_ov, flag_z, flag_s} !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b%b%b%b, want all 0",
                         busy, done, result, flag_cy, flag_ov, flag_z, flag_s);
    end
    @(negedge clk);
    checks++;
    if ({alu_x, alu_y, alu_instr, alu_y_src_sel, alu_z_src_sel, alu_add_sub_sel} !== '0) begin
      errors++; $display("FAIL reset_alu_drive: got x=%h y=%h instr=%h, want 0", alu_x, alu_y, alu_instr);
    end
    rst = 1'b0;
  endtask

  task automatic test_add_overflow;
    int lat; logic [4:0] sel; logic bsy;
    issue(3'd0, 16'h7FFF, 16'h0001, 8'h55, 1'b0, lat, sel, bsy);
    checks++;
    if (lat !== 1 || bsy !== 1'b1 || sel !== 5'b0_000_0) begin
      errors++; $display("FAIL add_timing: got lat=%0d busy=%b sel=%b, want 1 1 00000", lat, bsy, sel);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL add_busy_in_done: got %b, want 0", busy);
    end
    checks++;
    if ({result, flag_cy, flag_ov, flag_z, flag_s} !== {16'h8000, 4'b0101}) begin
      errors++; $display("FAIL add_result: got %h cy%b ov%b z%b s%b, want 8000 cy0 ov1 z0 s1",
                         result, flag_cy, flag_ov, flag_z, flag_s);
    end
    m_cy = 1'b0; m_ov = 1'b1;
  endtask

  task automatic test_sub_imm;
    int lat; logic [4:0] sel; logic bsy;
    issue(3'd1, 16'h0010, 16'hABCD, 8'h10, 1'b1, lat, sel, bsy);
    checks++;
    if (lat !== 1 || sel !== 5'b1_000_1) begin
      errors++; $display("FAIL sub_imm_sel: got lat=%0d sel=%b, want 1 10001", lat, sel);
    end
    checks++;
    if ({result, flag_cy, flag_ov, flag_z, flag_s} !== {16'h0000, 4'b1010}) begin
      errors++; $display("FAIL sub_imm_result: got %h cy%b ov%b z%b s%b, want 0000 cy1 ov0 z1 s0",
                         result, flag_cy, flag_ov, flag_z, flag_s);
    end
    m_cy = 1'b1; m_ov = 1'b0;
  endtask

  task automatic test_mul_vectors;
    logic [2:0]  vo[4] = '{3'd6, 3'd7, 3'd7, 3'd7};
    logic [15:0] va[4] = '{16'h00FF, 16'h00FF, 16'h0080, 16'h00FF};
    logic [15:0] vb[4] = '{16'h00FF, 16'h00FF, 16'h0080, 16'h0002};
    logic [15:0] vr[4] = '{16'hFE01, 16'h0001, 16'h4000, 16'hFFFE};
    int lat; logic [4:0] sel; logic bsy;
    for (int k = 0; k < 4; k++) begin
      issue(vo[k], va[k], vb[k], 8'h00, 1'b0, lat, sel, bsy);
      checks++;
      if (lat !== 8 || bsy !== 1'b1) begin
        errors++; $display("FAIL mul_latency[%0d]: got lat=%0d busy=%b, want 8 1", k, lat, bsy);
      end
      checks++;
      if ({result, flag_cy, flag_ov, flag_z, flag_s} !== {vr[k], m_cy, m_ov, vr[k] == 16'h0, vr[k][15]}) begin
        errors++; $display("FAIL mul_result[%0d]: got %h cy%b ov%b z%b s%b, want %h cy%b ov%b",
                           k, result, flag_cy, flag_ov, flag_z, flag_s, vr[k], m_cy, m_ov);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 16'hF0F0; b = 16'hFFFF; imm_en = 1'b0;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (done !== 1'b1 && cnt < 5);
    checks++;
    if (cnt !== 2 || {result, flag_cy, flag_ov, flag_z, flag_s} !== {16'h0F0F, m_cy, m_ov, 2'b00}) begin
      errors++; $display("FAIL b2b_xor: got cnt=%0d result=%h cy%b ov%b z%b s%b, want 2 0F0F cy%b ov%b z0 s0",
                         cnt, result, flag_cy, flag_ov, flag_z, flag_s, m_cy, m_ov);
    end
    op = 3'd5; a = 16'h1234; b = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++; $display("FAIL b2b_accept: got done=%b busy=%b, want 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if ({done, result, flag_cy, flag_ov, flag_z, flag_s} !== {1'b1, 16'h3412, m_cy, m_ov, 2'b00}) begin
      errors++; $display("FAIL b2b_swap: got done=%b result=%h cy%b ov%b, want 1 3412 cy%b ov%b",
                         done, result, flag_cy, flag_ov, m_cy, m_ov);
    end
  endtask

  task automatic test_start_during_mul;
    int ndone; logic [15:0] got; logic [17:0] e;
    e = ref_op(3'd6, 16'h00C3, 16'h005A, 8'h00, 1'b0, m_cy, m_ov);
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 16'h00C3; b = 16'h005A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0001;
    ndone = 0; got = '0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin ndone++; got = result; end
    end
    checks++;
    if (ndone !== 1 || got !== e[15:0] || busy !== 1'b0) begin
      errors++; $display("FAIL start_during_mul: got dones=%0d result=%h busy=%b, want 1 %h 0",
                         ndone, got, busy, e[15:0]);
    end
  endtask

  task automatic test_reset_mid_mul;
    int ndone, lat; logic [4:0] sel; logic bsy;
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 16'h00FF; b = 16'h00FF;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, result, flag_cy, flag_ov, flag_z, flag_s, alu_x, alu_y, alu_instr,
         alu_y_src_sel, alu_z_src_sel, alu_add_sub_sel} !== '0) begin
      errors++; $display("FAIL reset_mid_mul: got busy=%b result=%h flags=%b%b%b%b alu_x=%h alu_y=%h, want 0",
                         busy, result, flag_cy, flag_ov, flag_z, flag_s, alu_x, alu_y);
    end
    @(negedge clk);
    rst = 1'b0;
    m_cy = 1'b0; m_ov = 1'b0;
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done === 1'b1) ndone++; end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL reset_no_done: got %0d dones, want 0", ndone);
    end
    issue(3'd0, 16'h0001, 16'h0001, 8'h00, 1'b0, lat, sel, bsy);
    checks++;
    if (lat !== 1 || {result, flag_cy, flag_ov, flag_z, flag_s} !== {16'h0002, 4'b0000}) begin
      errors++; $display("FAIL add_after_reset: got lat=%0d result=%h cy%b ov%b z%b s%b, want 1 0002 0000",
                         lat, result, flag_cy, flag_ov, flag_z, flag_s);
    end
  endtask

  task automatic test_random;
    int lat; logic [4:0] sel; logic bsy;
    logic [2:0] o; logic [15:0] xa, xb; logic [7:0] xi; logic xe;
    logic [17:0] e;
    for (int k = 0; k < 40; k++) begin
      o = 3'($urandom_range(0, 7)); xa = 16'($urandom); xb = 16'($urandom);
      xi = 8'($urandom); xe = 1'($urandom);
      e = ref_op(o, xa, xb, xi, xe, m_cy, m_ov);
      issue(o, xa, xb, xi, xe, lat, sel, bsy);
      checks++;
      if (lat !== ((o >= 3'd6) ? 8 : 1)) begin
        errors++; $display("FAIL rand_latency[%0d]: op=%0d got %0d", k, o, lat);
      end
      checks++;
      if ({result, flag_cy, flag_ov, flag_z, flag_s} !== {e[15:0], e[17], e[16], e[15:0] == 16'h0, e[15]}) begin
        errors++; $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h imm=%h ie=%b got %h cy%b ov%b z%b s%b, want %h cy%b ov%b",
                           k, o, xa, xb, xi, xe, result, flag_cy, flag_ov, flag_z, flag_s, e[15:0], e[17], e[16]);
      end
      m_cy = e[17]; m_ov = e[16];
    end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_back_to_back;
    test_sub_imm;
    test_mul_vectors;
    test_start_during_mul;
    test_random;
    test_reset_mid_mul;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequencer that owns the control inputs of the ALU (adder/subtractor, AND/OR/XOR, byte-swap, Y-source mux) and issues one operation per request. Single-cycle ops pass through in one execute cycle. 8x8 unsigned/signed multiplies run as 8 shift-add iterations on the ALU adder, so no dedicated multiplier is needed. It sits between the instruction decoder and the ALU, registers the result and flags, and handshakes with start/busy/done.

## Interface
- No parameters; all widths fixed (16-bit datapath, 8-bit immediate).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SWAP, 110 UMUL, 111 SMUL.
- imm_en  in  1  ADD/SUB only: Y operand = {8'h00, imm}; ignored for other ops.
- a  in  16  X operand / multiplicand (MUL uses a[7:0]).
- b  in  16  Y operand / multiplier (MUL uses b[7:0]).
- imm  in  8  immediate byte.
- alu_x  out  16  to ALU x.
- alu_y  out  16  to ALU y.
- alu_instr  out  8  to ALU instr.
- alu_y_src_sel  out  1  to ALU Y mux: 0 = y, 1 = immediate.
- alu_z_src_sel  out  3  to ALU result mux: 000 adder, 001 AND, 010 OR, 011 XOR, 101 swap.
- alu_add_sub_sel  out  1  to ALU: 0 add, 1 subtract.
- alu_z  in  16  ALU result.
- alu_cy  in  1  ALU carry.
- alu_ov  in  1  ALU overflow.
- busy  out  1  operation in flight.
- done  out  1  one-cycle completion pulse.
- result  out  16  registered result; held until next completion.
- flag_cy  out  1  carry flag.
- flag_ov  out  1  overflow flag.
- flag_z  out  1  zero flag.
- flag_s  out  1  sign flag.

## Operation
- States: IDLE, EXEC (single-cycle ops), MUL (iteration counter i = 0..7).
- IDLE with start=1: latch op, a, b, imm, imm_en. Go to EXEC for op 000-101, or to MUL with i=0 and acc=0 for 110/111.
- EXEC:
  - Drive alu_x=a, alu_y=b, alu_instr=imm.
  - alu_z_src_sel from op: ADD/SUB→000, AND→001, OR→010, XOR→011, SWAP→101.
  - alu_add_sub_sel=1 only for SUB; alu_y_src_sel=imm_en for ADD/SUB, else 0.
  - At the edge: result←alu_z, done←1, return to IDLE.
- MUL:
  - mcand = a[7:0] zero-extended (UMUL) or sign-extended (SMUL) to 16 bits.
  - Each cycle: alu_x=acc; alu_y = b[i] ? (mcand << i) : 16'h0000; alu_z_src_sel=000; alu_y_src_sel=0.
  - alu_add_sub_sel=1 only when op=SMUL and i=7 (two's-complement weight −2^7); otherwise 0.
  - Each edge: acc←alu_z, i←i+1. At i=7: result←alu_z, done←1, return to IDLE.
  - Product is taken modulo 2^16 and equals the exact 8x8 product for both signednesses.
- Flags are updated at the completion edge only:
  - flag_z = (result==0), flag_s = result[15] for all ops.
  - flag_cy/flag_ov ← alu_cy/alu_ov for ADD/SUB only; held otherwise.
- When not in EXEC/MUL: alu_x, alu_y, alu_instr = 0; all selects = 0.
- busy = (state != IDLE).
- start while busy is ignored; it is neither queued nor flagged.

## Timing
- Reset (async, any state, including mid-multiply):
  - Next state IDLE; i and acc cleared.
  - busy=0, done=0, result=16'h0000, all flags=0.
  - ALU drive outputs 0.
  - An aborted operation produces no done.
- Acceptance edge E0: busy=1 from E0.
- Single-cycle op: done high for exactly the cycle after E1; busy low in that cycle.
- MUL: iterations at E1..E8; done high for the cycle after E8, so latency is 8 cycles.
- done is a single-cycle pulse. A start asserted during the done cycle is accepted (state is IDLE), giving back-to-back throughput of 1 op per 2 cycles for single ops and 1 per 9 cycles for MUL.
- ALU is combinational. alu_* outputs are decoded from registered state, so each ALU pass has a full cycle.

## Test plan
- ADD, a=7FFF, b=0001 -> done 1 cycle after accept; result=8000, flag_ov=1, flag_cy=0, flag_s=1, flag_z=0.
- SUB with imm_en=1, a=0010, imm=10 -> alu_y_src_sel=1 during EXEC; result=0000, flag_z=1.
- UMUL, a=00FF, b=00FF -> busy for 8 cycles, then result=FE01. SMUL with the same operands -> result=0001. SMUL a=0080, b=0080 -> 4000. SMUL a=00FF, b=0002 -> FFFE.
- Back-to-back: XOR (a=F0F0, b=FFFF → 0F0F) with start held high into the done cycle, then SWAP a=1234 -> second done 2 cycles after the first; result=3412; flag_cy/flag_ov unchanged.
- start pulsed at iteration 3 of a UMUL -> ignored; exactly one done; result is the correct product.
- rst asserted at MUL iteration 4 (asynchronous, mid-cycle) -> outputs clear immediately, no done; a following ADD 0001+0001 returns 0002.
